// File: rtl/p2_fetch_unit.sv
// P2 fetch stage: issues sequential instruction fetches under a queue-credit limit
// and buffers in-order memory responses, tagged with their pc, for decode.
module p2_fetch_unit #(
  parameter int               DATAW    = 32,
  parameter int               QDEPTH   = 4,
  parameter logic [DATAW-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_en,
  input  logic [DATAW-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [DATAW-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [DATAW-1:0] imem_rsp_data,
  input  logic             imem_rsp_fault,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [DATAW-1:0] dec_insn,
  output logic [DATAW-1:0] dec_pc,
  output logic             dec_fault
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  state_e           state_q;
  logic [DATAW-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]    ahead_q, ahead_d, atail_q, atail_d;

  logic [DATAW-1:0] q_insn_q  [QDEPTH];
  logic [DATAW-1:0] q_pc_q    [QDEPTH];
  logic             q_fault_q [QDEPTH];
  logic [DATAW-1:0] addr_fifo_q [QDEPTH];

  logic          req_fire;
  logic          rsp_live;
  logic          fault_live;
  logic          pop;
  logic [CW:0]   credit_used;

  // Credit uses only registered counts, so a request never depends on a same-cycle response.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && (state_q == RUN) && !redirect_en && (credit_used < QDEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live   = imem_rsp_valid && !redirect_en && (drop_cnt_q == '0);
  assign fault_live = rsp_live && imem_rsp_fault;

  assign dec_valid = (count_q != '0);
  assign dec_insn  = q_insn_q[head_q];
  assign dec_pc    = q_pc_q[head_q];
  assign dec_fault = q_fault_q[head_q];
  assign pop       = dec_valid && dec_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + DATAW'(4);
    end

    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);

    // Everything still outstanding after a redirect or a fault is stale, including
    // a request accepted in the same cycle as the fault.
    drop_cnt_d = drop_cnt_q;
    if (redirect_en || fault_live) begin
      drop_cnt_d = inflight_d;
    end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end

    if (redirect_en) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + CW'(rsp_live) - CW'(pop);
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(rsp_live);
    end

    ahead_d = ahead_q + PW'(imem_rsp_valid);
    atail_d = atail_q + PW'(req_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else if (redirect_en) begin
      state_q <= RUN;
    end else if (fault_live) begin
      state_q <= HALTED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      ahead_q    <= '0;
      atail_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ahead_q    <= ahead_d;
      atail_q    <= atail_d;
    end
  end

  // The address FIFO is never flushed: dropped responses still consume their entry.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      addr_fifo_q[atail_q] <= imem_req_addr;
    end
    if (rsp_live) begin
      q_insn_q[tail_q]  <= imem_rsp_fault ? '0 : imem_rsp_data;
      q_pc_q[tail_q]    <= addr_fifo_q[ahead_q];
      q_fault_q[tail_q] <= imem_rsp_fault;
    end
  end

endmodule

// File: tb/tb_p2_fetch_unit.sv
// Directed bench for p2_fetch_unit: cycle-vector table plus hand-written
// redirect, fault and stall sequences against an in-order memory model.
module tb_p2_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_fault;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_insn;
  logic [31:0] dec_pc;
  logic        dec_fault;

  p2_fetch_unit #(.DATAW(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_fault (imem_rsp_fault),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_insn       (dec_insn),
    .dec_pc         (dec_pc),
    .dec_fault      (dec_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rstBefore;
    bit          redir;
    logic [31:0] rpc;
    bit          rdy;
    bit          drdy;
    bit          expV;
    logic [31:0] expAddr;
    bit          expDv;
    logic [31:0] expPc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
  } decEnt_t;

  vec_t        vecs[$];
  memReq_t     memQ[$];
  decEnt_t     decLog[$];
  int          checks = 0;
  int          failures = 0;
  int          cycleNum = 0;
  int          memLat = 1;
  bit          faultEn = 1'b0;
  logic [31:0] faultAddr = 32'h0;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hC0DE_0000 | {16'h0, addr[15:0]};
  endfunction

  function automatic vec_t mk(input bit r, input bit rdy, input bit drdy, input bit v,
                              input logic [31:0] a, input bit dv, input logic [31:0] pc);
    vec_t t;
    t.rstBefore = r;
    t.redir     = 1'b0;
    t.rpc       = 32'h0;
    t.rdy       = rdy;
    t.drdy      = drdy;
    t.expV      = v;
    t.expAddr   = a;
    t.expDv     = dv;
    t.expPc     = pc;
    return t;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    dec_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    imem_rsp_fault = 1'b0;
    memQ.delete();
    decLog.delete();
    #1;
    compare("rst_reqValid", imem_req_valid, 0);
    compare("rst_decValid", dec_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycleNum = 0;
  endtask

  // In-order memory: head request answers once its due cycle is reached.
  task automatic driveMem();
    if (memQ.size() > 0 && memQ[0].due <= cycleNum) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_fault = faultEn && (memQ[0].addr == faultAddr);
      imem_rsp_data  = imem_rsp_fault ? 32'hDEAD_BEEF : memWord(memQ[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_fault = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    redirect_en    = v.redir;
    redirect_pc    = v.rpc;
    imem_req_ready = v.rdy;
    dec_ready      = v.drdy;
    driveMem();
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    compare($sformatf("row%0d_reqValid", idx), imem_req_valid, v.expV);
    if (v.expV) compare($sformatf("row%0d_reqAddr", idx), imem_req_addr, v.expAddr);
    compare($sformatf("row%0d_decValid", idx), dec_valid, v.expDv);
    if (v.expDv) begin
      compare($sformatf("row%0d_decPc", idx), dec_pc, v.expPc);
      compare($sformatf("row%0d_decInsn", idx), dec_insn, memWord(v.expPc));
      compare($sformatf("row%0d_decFault", idx), dec_fault, 0);
    end
  endtask

  task automatic finishCycle();
    memReq_t r;
    decEnt_t e;
    if (imem_rsp_valid) memQ.delete(0);
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr;
      r.due  = cycleNum + memLat;
      memQ.push_back(r);
    end
    if (dec_valid && dec_ready) begin
      e.pc    = dec_pc;
      e.insn  = dec_insn;
      e.fault = dec_fault;
      decLog.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cycleNum++;
  endtask

  task automatic cycleWith(input bit redir, input logic [31:0] rpc, input bit rdy, input bit drdy);
    vec_t v;
    v = mk(1'b0, rdy, drdy, 1'b0, 32'h0, 1'b0, 32'h0);
    v.redir = redir;
    v.rpc   = rpc;
    applyStimulus(v);
    finishCycle();
  endtask

  task automatic waitLog(input string name, input int n, input bit drdy);
    for (int i = 0; i < 60 && decLog.size() < n; i++) cycleWith(1'b0, 32'h0, 1'b1, drdy);
    compare(name, decLog.size() >= n, 1);
  endtask

  task automatic checkLog(input string name, input int k, input logic [31:0] pc, input bit flt);
    if (decLog.size() > k) begin
      compare({name, "_pc"}, decLog[k].pc, pc);
      compare({name, "_fault"}, decLog[k].fault, flt);
      compare({name, "_insn"}, decLog[k].insn, flt ? 32'h0 : memWord(pc));
    end
  endtask

  initial begin
    int haltReq;
    rst = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    dec_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    imem_rsp_fault = 1'b0;

    // Streaming with 1-cycle memory: decode trails the request address by 8.
    vecs.push_back(mk(1, 1, 1, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h08));
    vecs.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h0C));
    // Decode stalled: credit stops after four requests, then drains and resumes at 0x10.
    vecs.push_back(mk(1, 1, 0, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 1, 0, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 1, 0, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 1, 0, 1, 32'h0C, 1, 32'h00));
    vecs.push_back(mk(0, 1, 0, 0, 32'h00, 1, 32'h00));
    vecs.push_back(mk(0, 1, 0, 0, 32'h00, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 0, 32'h00, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h08));
    vecs.push_back(mk(0, 1, 1, 1, 32'h18, 1, 32'h0C));
    vecs.push_back(mk(0, 1, 1, 1, 32'h1C, 1, 32'h10));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rstBefore) doReset();
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
      finishCycle();
    end

    // Redirect with two 3-cycle requests outstanding: both responses are dropped.
    memLat = 3;
    doReset();
    cycleWith(1'b0, 32'h0, 1'b1, 1'b1);
    cycleWith(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(mk(0, 1, 1, 0, 32'h0, 0, 32'h0));
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    #1;
    compare("redir_reqValidLow", imem_req_valid, 0);
    finishCycle();
    applyStimulus(mk(0, 1, 1, 0, 32'h0, 0, 32'h0));
    compare("redir_nextReqValid", imem_req_valid, 1);
    compare("redir_nextReqAddr", imem_req_addr, 32'h100);
    compare("redir_queueEmpty", dec_valid, 0);
    finishCycle();
    waitLog("redir_logCount", 2, 1'b1);
    checkLog("redir_e0", 0, 32'h100, 1'b0);
    checkLog("redir_e1", 1, 32'h104, 1'b0);

    // Redirect coinciding with a live response and a decode pop.
    memLat = 2;
    doReset();
    for (int i = 0; i < 4; i++) cycleWith(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(mk(0, 1, 1, 0, 32'h0, 0, 32'h0));
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    #1;
    compare("coinc_rspPresent", imem_rsp_valid, 1);
    compare("coinc_popValid", dec_valid, 1);
    compare("coinc_popPc", dec_pc, 32'h4);
    finishCycle();
    applyStimulus(mk(0, 1, 1, 0, 32'h0, 0, 32'h0));
    compare("coinc_nextReqValid", imem_req_valid, 1);
    compare("coinc_nextReqAddr", imem_req_addr, 32'h200);
    compare("coinc_queueEmpty", dec_valid, 0);
    finishCycle();
    waitLog("coinc_logCount", 3, 1'b1);
    checkLog("coinc_e0", 0, 32'h0, 1'b0);
    checkLog("coinc_e1", 1, 32'h4, 1'b0);
    checkLog("coinc_e2", 2, 32'h200, 1'b0);

    // Fault at 0x8: younger responses dropped, fetch halts until redirect 0x40.
    memLat = 2;
    doReset();
    faultEn = 1'b1;
    faultAddr = 32'h8;
    for (int i = 0; i < 6; i++) cycleWith(1'b0, 32'h0, 1'b1, 1'b1);
    haltReq = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(mk(0, 1, 1, 0, 32'h0, 0, 32'h0));
      if (imem_req_valid) haltReq++;
      finishCycle();
    end
    compare("fault_haltedRequests", haltReq, 0);
    compare("fault_logCount", decLog.size(), 3);
    checkLog("fault_e0", 0, 32'h0, 1'b0);
    checkLog("fault_e1", 1, 32'h4, 1'b0);
    checkLog("fault_e2", 2, 32'h8, 1'b1);
    faultEn = 1'b0;
    cycleWith(1'b1, 32'h40, 1'b1, 1'b1);
    applyStimulus(mk(0, 1, 1, 0, 32'h0, 0, 32'h0));
    compare("fault_resumeValid", imem_req_valid, 1);
    compare("fault_resumeAddr", imem_req_addr, 32'h40);
    finishCycle();
    waitLog("fault_resumeLog", 4, 1'b1);
    checkLog("fault_e3", 3, 32'h40, 1'b0);

    // Memory not ready for 5 cycles: request held, no skipped or repeated pc.
    memLat = 1;
    doReset();
    cycleWith(1'b0, 32'h0, 1'b1, 1'b1);
    cycleWith(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mk(0, 0, 1, 0, 32'h0, 0, 32'h0));
      compare($sformatf("stall%0d_reqValid", i), imem_req_valid, 1);
      compare($sformatf("stall%0d_reqAddr", i), imem_req_addr, 32'h8);
      finishCycle();
    end
    waitLog("stall_logCount", 8, 1'b1);
    for (int k = 0; k < 8; k++) checkLog($sformatf("stall_e%0d", k), k, 32'(4 * k), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
